// File: rtl/mem_port_arbiter.sv
// Single-port unified memory arbiter between instruction fetch and the MEM stage.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_kill,
  output logic        if_stall,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_stall,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  owner_e owner_q, owner_d;
  logic   if_gnt, dm_gnt, starve_trip;

`ifdef MEM_ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt_q, starve_cnt_d;

  assign starve_trip = ({29'd0, starve_cnt_q} >= STARVE_LIMIT);

  // Saturating count of consecutive cycles fetch wanted the port and lost it.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req || if_gnt)
      starve_cnt_d = 3'd0;
    else if (starve_cnt_q != 3'd7)
      starve_cnt_d = starve_cnt_q + 3'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) starve_cnt_q <= 3'd0;
    else          starve_cnt_q <= starve_cnt_d;
  end
`else
  // Strict data priority; the limit only matters when the guard is built.
  assign starve_trip = 1'b0 & (STARVE_LIMIT != 0);
`endif

  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (reset_n) begin
      if (dm_req && !(if_req && starve_trip)) dm_gnt = 1'b1;
      else if (if_req)                        if_gnt = 1'b1;
    end
  end

  assign if_stall = reset_n & if_req & ~if_gnt;
  assign dm_stall = reset_n & dm_req & ~dm_gnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'h0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    owner_d   = OWN_NONE;
    if (dm_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_be    = dm_we ? dm_be : 4'hF;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      if (!dm_we) owner_d = OWN_DM;
    end else if (if_gnt) begin
      mem_en   = 1'b1;
      mem_be   = 4'hF;
      mem_addr = if_addr;
      // A killed fetch still reads memory; only its response is suppressed.
      if (!if_kill) owner_d = OWN_IF;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) owner_q <= OWN_NONE;
    else          owner_q <= owner_d;
  end

  assign if_rvalid = (owner_q == OWN_IF);
  assign dm_rvalid = (owner_q == OWN_DM);
  assign if_rdata  = if_rvalid ? mem_rdata : 32'd0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter; inputs change on negedge, checks
// are taken 1ns later so registered outputs reflect the preceding posedge.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req, if_kill, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [3:0]  dm_be;
  logic        if_stall, if_rvalid, dm_stall, dm_rvalid;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  int vec = 0;
  int err = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill), .if_stall(if_stall),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_stall(dm_stall), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic idle();
    if_req = 0; if_kill = 0; if_addr = 0;
    dm_req = 0; dm_we = 0; dm_be = 0; dm_addr = 0; dm_wdata = 0;
    mem_rdata = 0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 0; idle();
    if_req = 1; dm_req = 1; if_addr = 32'h44; dm_addr = 32'h88;
    step(); #1;
    vec++; if (mem_en !== 1'b0) begin err++; $display("FAIL rst_mem_en got %b want 0", mem_en); end
    vec++; if (if_stall !== 1'b0 || dm_stall !== 1'b0) begin err++; $display("FAIL rst_stall got %b%b want 00", if_stall, dm_stall); end
    vec++; if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0) begin err++; $display("FAIL rst_rvalid got %b%b want 00", if_rvalid, dm_rvalid); end
    vec++; if (mem_addr !== 32'd0 || mem_be !== 4'd0) begin err++; $display("FAIL rst_mem_bus got %h/%h want 0/0", mem_addr, mem_be); end
    idle();
    step(); reset_n = 1;
    step(); #1;
    vec++; if (if_rvalid !== 1'b0 || dm_rvalid !== 1'b0 || if_rdata !== 0 || dm_rdata !== 0) begin
      err++; $display("FAIL post_rst_resp got %b%b %h %h want 00 0 0", if_rvalid, dm_rvalid, if_rdata, dm_rdata); end
  endtask

  task automatic test_fetch();
    step(); idle(); if_req = 1; if_addr = 32'h10; #1;
    vec++; if (mem_addr !== 32'h10 || if_stall !== 1'b0 || mem_en !== 1'b1) begin
      err++; $display("FAIL fetch_grant got addr=%h stall=%b en=%b want 10 0 1", mem_addr, if_stall, mem_en); end
    vec++; if (mem_we !== 1'b0 || mem_be !== 4'hF) begin err++; $display("FAIL fetch_drive got we=%b be=%h want 0 f", mem_we, mem_be); end
    step(); if_req = 0; mem_rdata = 32'h00500093; #1;
    vec++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h00500093) begin
      err++; $display("FAIL fetch_resp got %b %h want 1 00500093", if_rvalid, if_rdata); end
    vec++; if (dm_rvalid !== 1'b0 || dm_rdata !== 0 || mem_en !== 1'b0) begin
      err++; $display("FAIL fetch_other got dmv=%b dmd=%h en=%b want 0 0 0", dm_rvalid, dm_rdata, mem_en); end
  endtask

  task automatic test_contention();
    step(); idle(); if_req = 1; if_addr = 32'h14; dm_req = 1; dm_addr = 32'h200; #1;
    vec++; if (if_stall !== 1'b1 || dm_stall !== 1'b0 || mem_addr !== 32'h200 || mem_be !== 4'hF) begin
      err++; $display("FAIL cont_grant got ifs=%b dms=%b addr=%h be=%h want 1 0 200 f", if_stall, dm_stall, mem_addr, mem_be); end
    step(); dm_req = 0; mem_rdata = 32'hCAFE0001; #1;
    vec++; if (dm_rvalid !== 1'b1 || dm_rdata !== 32'hCAFE0001 || if_rvalid !== 1'b0 || if_rdata !== 0) begin
      err++; $display("FAIL cont_load_resp got dmv=%b dmd=%h ifv=%b ifd=%h want 1 cafe0001 0 0", dm_rvalid, dm_rdata, if_rvalid, if_rdata); end
    vec++; if (if_stall !== 1'b0 || mem_addr !== 32'h14) begin
      err++; $display("FAIL cont_b2b_fetch got stall=%b addr=%h want 0 14", if_stall, mem_addr); end
    step(); if_req = 0; mem_rdata = 32'h00001234; #1;
    vec++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h1234 || dm_rvalid !== 1'b0) begin
      err++; $display("FAIL cont_fetch_resp got ifv=%b ifd=%h dmv=%b want 1 1234 0", if_rvalid, if_rdata, dm_rvalid); end
  endtask

  task automatic test_store();
    step(); idle(); dm_req = 1; dm_we = 1; dm_be = 4'b0011; dm_addr = 32'h300; dm_wdata = 32'hBEEF; #1;
    vec++; if (mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_wdata !== 32'hBEEF || mem_addr !== 32'h300 || dm_stall !== 1'b0) begin
      err++; $display("FAIL store_drive got we=%b be=%b wd=%h addr=%h stall=%b want 1 0011 beef 300 0", mem_we, mem_be, mem_wdata, mem_addr, dm_stall); end
    step(); idle(); mem_rdata = 32'h5555AAAA; #1;
    vec++; if (dm_rvalid !== 1'b0 || if_rvalid !== 1'b0 || dm_rdata !== 0) begin
      err++; $display("FAIL store_no_resp got dmv=%b ifv=%b dmd=%h want 0 0 0", dm_rvalid, if_rvalid, dm_rdata); end
    vec++; if (mem_en !== 1'b0 || mem_be !== 4'd0 || mem_wdata !== 0 || mem_we !== 1'b0) begin
      err++; $display("FAIL idle_bus got en=%b be=%h wd=%h we=%b want 0 0 0 0", mem_en, mem_be, mem_wdata, mem_we); end
  endtask

  task automatic test_kill();
    step(); idle(); if_req = 1; if_addr = 32'h20; if_kill = 1; #1;
    vec++; if (mem_en !== 1'b1 || mem_addr !== 32'h20) begin
      err++; $display("FAIL kill_still_reads got en=%b addr=%h want 1 20", mem_en, mem_addr); end
    step(); if_kill = 0; if_addr = 32'h24; mem_rdata = 32'hDEAD0000; #1;
    vec++; if (if_rvalid !== 1'b0 || if_rdata !== 0) begin
      err++; $display("FAIL kill_no_resp got %b %h want 0 0", if_rvalid, if_rdata); end
    step(); if_req = 0; if_kill = 1; mem_rdata = 32'h00000077; #1;
    vec++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h77) begin
      err++; $display("FAIL unkilled_resp got %b %h want 1 77", if_rvalid, if_rdata); end
    if_kill = 0;
  endtask

  task automatic test_starve();
    bit exp_fetch;
    step(); idle(); step();
    if_req = 1; if_addr = 32'h30; dm_req = 1; dm_addr = 32'h400;
    for (int i = 0; i < 10; i++) begin
      #1;
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_fetch = (i % 5 == 4);
`else
      exp_fetch = 1'b0;
`endif
      vec++; if (if_stall !== !exp_fetch || dm_stall !== exp_fetch || mem_addr !== (exp_fetch ? 32'h30 : 32'h400)) begin
        err++; $display("FAIL starve_cyc%0d got ifs=%b dms=%b addr=%h want %b %b fetch=%b", i, if_stall, dm_stall, mem_addr, !exp_fetch, exp_fetch, exp_fetch); end
      step();
    end
    idle();
  endtask

  task automatic test_reset_mid_load();
    step(); idle(); dm_req = 1; dm_addr = 32'h40; if_req = 1; #1;
    vec++; if (dm_stall !== 1'b0 || mem_en !== 1'b1) begin
      err++; $display("FAIL midrst_grant got stall=%b en=%b want 0 1", dm_stall, mem_en); end
    #1 reset_n = 0; #1;
    vec++; if (mem_en !== 1'b0 || dm_stall !== 1'b0 || if_stall !== 1'b0 || mem_addr !== 0) begin
      err++; $display("FAIL midrst_outs got en=%b dms=%b ifs=%b addr=%h want 0 0 0 0", mem_en, dm_stall, if_stall, mem_addr); end
    step(); mem_rdata = 32'h99999999; #1;
    vec++; if (dm_rvalid !== 1'b0 || dm_rdata !== 0 || mem_en !== 1'b0) begin
      err++; $display("FAIL midrst_hold got dmv=%b dmd=%h en=%b want 0 0 0", dm_rvalid, dm_rdata, mem_en); end
    step(); idle(); reset_n = 1; mem_rdata = 32'h99999999;
    for (int i = 0; i < 2; i++) begin
      step(); #1;
      vec++; if (dm_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
        err++; $display("FAIL midrst_after%0d got dmv=%b ifv=%b want 0 0", i, dm_rvalid, if_rvalid); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_contention();
    test_store();
    test_kill();
    test_starve();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-port, synchronous-read unified memory between the instruction fetch stage and the load/store (MEM) stage of the 5-stage RV32I core. It grants at most one access per cycle and returns read data one cycle later, tagged to the requester that issued it. When a requester loses arbitration it receives a stall (fetch stall drives the fetch stage's `pc_write` low). Fetches killed by a pipeline flush have their responses discarded.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: consecutive lost fetch cycles before fetch is forced ahead of data (starvation guard only).

Ports:
- `clk`, input, 1: clock.
- `reset_n`, input, 1: reset, asynchronous, active-low.
- `if_req`, input, 1: fetch request, held until granted.
- `if_addr`, input, 32: fetch word address (byte address, bits [1:0] ignored).
- `if_kill`, input, 1: flush; discards the fetch granted this cycle.
- `if_stall`, output, 1: fetch not granted this cycle.
- `if_rvalid`, output, 1: fetch data valid.
- `if_rdata`, output, 32: fetch data.
- `dm_req`, input, 1: data request, held until granted.
- `dm_we`, input, 1: 1 = store, 0 = load.
- `dm_be`, input, 4: store byte enables.
- `dm_addr`, input, 32: data byte address.
- `dm_wdata`, input, 32: store data.
- `dm_stall`, output, 1: data access not granted this cycle.
- `dm_rvalid`, output, 1: load data valid.
- `dm_rdata`, output, 32: load data.
- `mem_en`, output, 1: memory access this cycle.
- `mem_we`, output, 1: memory write.
- `mem_be`, output, 4: memory byte enables.
- `mem_addr`, output, 32: memory byte address.
- `mem_wdata`, output, 32: memory write data.
- `mem_rdata`, input, 32: memory read data, valid the cycle after a read enable.

## Operation

**Grant (combinational, same cycle).**
- Only one of `dm_req` / `if_req` is asserted: that side is granted.
- Both are asserted: data wins, unless the starvation guard has tripped.
- `if_stall = if_req & ~if_gnt`.
- `dm_stall = dm_req & ~dm_gnt`.

**Memory drive.**
- Fetch grant: `mem_en=1`, `mem_we=0`, `mem_be=4'hF`, `mem_addr=if_addr`.
- Data grant: `mem_en=1`, `mem_we=dm_we`, `mem_be` = `dm_we ? dm_be : 4'hF`, `mem_addr=dm_addr`, `mem_wdata=dm_wdata`.
- No grant: `mem_en=0` and all other memory outputs are 0.

**Response owner.** A 2-bit register holds one of three states:
- `NONE`: no response due.
- `IF`: set by a fetch grant with `if_kill=0`. Next cycle: `if_rvalid=1`, `if_rdata=mem_rdata`.
- `DM`: set by a load grant. Next cycle: `dm_rvalid=1`, `dm_rdata=mem_rdata`.

Other owner rules:
- A store grant, a killed fetch, or no grant all load `NONE`.
- The `rdata` output of the non-owning side is 0.

**Starvation counter** (3-bit, saturating):
- Increments each cycle in which `if_req & ~if_gnt`.
- Clears on any fetch grant or when `if_req=0`.

## Timing
- Grant and stall: 0-cycle, combinational from the requests.
- Read latency: exactly 1 cycle from grant to `rvalid`.
- Throughput: 1 access per cycle, with back-to-back grants to either side.
- Stores complete in the grant cycle and produce no `rvalid`.
- `if_kill` in the same cycle as a fetch grant: no `if_rvalid` the next cycle. The memory is still read.
- `if_kill` in the response cycle: no effect. `if_rvalid` still asserts, and the fetch stage discards the data.
- A request dropped before grant is legal and never gets a response.
- Reset values:
  - Owner `NONE`, counter 0.
  - `if_rvalid`, `dm_rvalid`, `if_rdata`, `dm_rdata` are 0.
  - While `reset_n=0`, all combinational outputs are forced to 0, including `mem_en` and both stalls.
- Reset asserted mid-operation: the pending response is dropped, and no `rvalid` follows release.

## Configuration
Macro `MEM_ARB_STARVE_GUARD_EN`:
- **Defined:** when the counter is at or above `STARVE_LIMIT` and both sides request, fetch is granted and data stalls for that cycle. The counter then clears.
- **Undefined:** strict data priority. The counter is not built, and fetch may stall indefinitely under continuous data requests.

## Test plan
- Fetch only: `if_req=1`, `if_addr=0x10`, `mem_rdata=0x00500093` the next cycle -> `mem_addr=0x10`, `if_stall=0`; 1 cycle later `if_rvalid=1`, `if_rdata=0x00500093`.
- Contention: `if_req=dm_req=1`, load at `0x200` -> `if_stall=1`, `dm_stall=0`, `mem_addr=0x200`; next cycle `dm_rvalid=1`, `if_rvalid=0`.
- Store: `dm_we=1`, `dm_be=4'b0011`, `dm_wdata=0xBEEF` -> `mem_we=1`, `mem_be=4'b0011`; no `dm_rvalid` next cycle.
- Kill: fetch granted with `if_kill=1` -> `if_rvalid=0` next cycle. A following unkilled fetch returns `if_rvalid=1`.
- Starvation: both request continuously.
  - With the guard and `STARVE_LIMIT=4`: 4 data grants, then 1 fetch grant with `dm_stall=1`, repeating.
  - Without the guard: fetch is never granted.
- Reset mid-load: assert `reset_n=0` in the load grant cycle and release 2 cycles later -> `dm_rvalid` stays 0 and all outputs are 0 during reset.
